mic1_microsequencer: RTL and testbench
======================================

Name: mic1_microsequencer

Overview:
- Control unit that sits directly upstream of the MIC1 datapath.
- Holds MPC and MIR, fetches 36-bit microinstructions from a synchronous control store, and splits MIR into datapath control fields (ALU, C-bus, B-select, memory strobes).
- Computes the next MPC from NEXT_ADDRESS, the JAM bits, the ALU N/Z flags and MBR.
- Each microinstruction takes 3 cycles: FETCH, LOAD, EXEC.

Parameters:
- CS_ADDR_W, 9, control-store address width (MPC width).
- CS_DATA_W, 36, control word width; field layout below is fixed for 36.
- RESET_MPC, 9'h000, MPC value loaded on reset.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- cs_addr  out  9  control-store address; always equals MPC.
- cs_rd  out  1  control-store read enable; high only in FETCH.
- cs_data  in  36  control word; valid in the cycle after cs_rd.
- alu_n  in  1  ALU negative flag of the current EXEC.
- alu_z  in  1  ALU zero flag of the current EXEC.
- mbr  in  8  low byte of MBR, used for JMPC.
- mem_busy  in  1  memory still completing a previous access.
- alu_ctrl  out  8  MIR[23:16] = SLL8, SRA1, F0, F1, ENA, ENB, INVA, INC.
- c_ctrl  out  9  MIR[15:7]; C-bus write enables.
- b_sel  out  4  MIR[3:0]; B-bus source select.
- mem_write  out  1  MIR[6], gated by exec_valid.
- mem_read  out  1  MIR[5], gated by exec_valid.
- mem_fetch  out  1  MIR[4], gated by exec_valid.
- exec_valid  out  1  the datapath executes MIR this cycle.
- mpc  out  9  current MPC, for debug.
- halted  out  1  sticky halt indicator.

Behaviour:
- MIR layout: [35:27] NEXT_ADDRESS, [26] JMPC, [25] JAMN, [24] JAMZ, [23:16] ALU, [15:7] C, [6:4] WRITE/READ/FETCH, [3:0] B.
- Reset (async): state=FETCH, MPC=RESET_MPC, MIR=0, N/Z latches=0. All outputs 0 except cs_addr=RESET_MPC; cs_rd asserts in the first cycle after reset deasserts.
- alu_ctrl, c_ctrl and b_sel continuously reflect MIR. Only exec_valid and the memory strobes are state-gated; the datapath commits only while exec_valid=1.

State machine:
- FETCH:
  - cs_rd=1, cs_addr=MPC.
  - If mem_busy=1: stay in FETCH with cs_rd=0 (stall).
  - Otherwise go to LOAD.
- LOAD:
  - At the end of the cycle, MIR <= cs_data.
  - Go to EXEC.
- EXEC:
  - If mem_busy=1: exec_valid=0, strobes=0, MPC unchanged, stay in EXEC.
  - Otherwise:
    - exec_valid=1 and strobes = MIR[6:4].
    - At the edge: N/Z latches <= alu_n/alu_z, MPC <= next_mpc.
    - Go to FETCH, or to HALT.
- HALT:
  - All strobes, cs_rd and exec_valid = 0; halted=1.
  - Exited only by reset.

Next-address rule (from MIR and the live flags in EXEC):
- base = NEXT_ADDRESS.
- If JMPC: base[7:0] = base[7:0] | mbr.
- base[8] = NEXT_ADDRESS[8] | (JAMN & alu_n) | (JAMZ & alu_z).

Halt and wrap-around:
- If JMPC=JAMN=JAMZ=0 and NEXT_ADDRESS == current MPC (self-loop), the EXEC completes normally: it commits and MPC is unchanged. The next state is then HALT, not FETCH.
- MPC wraps naturally in 9 bits; no overflow flag.

Simultaneous and mid-operation events:
- mem_busy rising in the LOAD cycle does not stall LOAD. The stall applies from EXEC.
- Reset asserted in any state aborts immediately: outputs clear asynchronously and the in-flight microinstruction is dropped.

Test Plan:
- Reset then release, control store word at 0x000 = NEXT 0x005, ALU 0x3C, C 0x001, B 0x2, no JAM -> cs_rd pulses at cycle 1; exec_valid at cycle 3 with alu_ctrl=0x3C, c_ctrl=0x001, b_sel=0x2; then mpc=0x005.
- JAMZ word, NEXT 0x010: alu_z=1 gives mpc=0x110; alu_z=0 gives mpc=0x010. Repeat with JAMN/alu_n for the same results.
- JMPC word, NEXT 0x100, mbr=0x59 -> mpc=0x159. With NEXT 0x000 and mbr=0xFF -> mpc=0x0FF.
- READ word (MIR[5]=1) with mem_busy held high for 2 cycles entering EXEC -> exec_valid and mem_read stay 0 for 2 cycles, then assert for exactly 1 cycle; MPC advances once.
- Word at 0x020 with NEXT=0x020, no JAM -> one exec_valid pulse, then halted=1. cs_rd stays 0 for 10+ cycles; reset clears halted and mpc=0x000.
- Assert reset during EXEC of a WRITE word -> mem_write drops the same cycle (async), MIR=0; fetch restarts at 0x000 after release.

Source files
------------

// File: rtl/mic1_microsequencer.sv
// MIC1 microsequencer: holds MPC/MIR, fetches microinstructions from a synchronous
// control store and runs each one through a FETCH / LOAD / EXEC sequence.
module mic1_microsequencer #(
    parameter int unsigned          CS_ADDR_W = 9,
    parameter int unsigned          CS_DATA_W = 36,
    parameter logic [CS_ADDR_W-1:0] RESET_MPC = 9'h000
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic [CS_ADDR_W-1:0] cs_addr,
    output logic                 cs_rd,
    input  logic [CS_DATA_W-1:0] cs_data,
    input  logic                 alu_n,
    input  logic                 alu_z,
    input  logic [7:0]           mbr,
    input  logic                 mem_busy,
    output logic [7:0]           alu_ctrl,
    output logic [8:0]           c_ctrl,
    output logic [3:0]           b_sel,
    output logic                 mem_write,
    output logic                 mem_read,
    output logic                 mem_fetch,
    output logic                 exec_valid,
    output logic [CS_ADDR_W-1:0] mpc,
    output logic                 halted
);

    localparam int unsigned JMPC_BIT = CS_DATA_W - 1 - CS_ADDR_W;
    localparam int unsigned JAMN_BIT = JMPC_BIT - 1;
    localparam int unsigned JAMZ_BIT = JMPC_BIT - 2;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CS_ADDR_W-1:0]   mpc_q, mpc_d;
    logic [CS_DATA_W-1:0]   mir_q, mir_d;

    logic [CS_ADDR_W-1:0]   next_addr;
    logic                   jmpc, jamn, jamz;
    logic [CS_ADDR_W-1:0]   next_mpc;
    logic                   self_loop;
    logic                   exec_fire;

    assign next_addr = mir_q[CS_DATA_W-1 -: CS_ADDR_W];
    assign jmpc      = mir_q[JMPC_BIT];
    assign jamn      = mir_q[JAMN_BIT];
    assign jamz      = mir_q[JAMZ_BIT];

    // A branch-free word that points at itself is the halt idiom.
    assign self_loop = !(jmpc || jamn || jamz) && (next_addr == mpc_q);
    assign exec_fire = (state_q == ST_EXEC) && !mem_busy;

    always_comb begin
        next_mpc = next_addr;
        if (jmpc) begin
            next_mpc[7:0] = next_addr[7:0] | mbr;
        end
        next_mpc[CS_ADDR_W-1] = next_addr[CS_ADDR_W-1] | (jamn & alu_n) | (jamz & alu_z);
    end

    always_comb begin
        mpc_d = mpc_q;
        mir_d = mir_q;
        if (exec_fire) begin
            mpc_d = next_mpc;
        end
        // cs_data carries the word requested in FETCH during this cycle.
        if (state_q == ST_LOAD) begin
            mir_d = cs_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mpc_q <= RESET_MPC;
            mir_q <= '0;
        end else begin
            mpc_q <= mpc_d;
            mir_q <= mir_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_FETCH: state_d = mem_busy ? ST_FETCH : ST_LOAD;
            ST_LOAD:  state_d = ST_EXEC;
            ST_EXEC: begin
                if (!mem_busy) begin
                    state_d = self_loop ? ST_HALT : ST_FETCH;
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        cs_rd      = 1'b0;
        exec_valid = 1'b0;
        halted     = 1'b0;
        case (state_q)
            ST_FETCH: cs_rd      = !mem_busy && !reset;
            ST_EXEC:  exec_valid = !mem_busy;
            ST_HALT:  halted     = 1'b1;
            default:  ;
        endcase
    end

    assign cs_addr   = mpc_q;
    assign mpc       = mpc_q;
    assign alu_ctrl  = mir_q[23:16];
    assign c_ctrl    = mir_q[15:7];
    assign b_sel     = mir_q[3:0];
    assign mem_write = mir_q[6] & exec_valid;
    assign mem_read  = mir_q[5] & exec_valid;
    assign mem_fetch = mir_q[4] & exec_valid;

endmodule

// File: tb/tb_mic1_microsequencer.sv
// Bench for mic1_microsequencer: directed microprograms plus random programs and
// random flags/stalls, all checked against a microinstruction-level model.
module tb_mic1_microsequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  cs_addr;
    logic        cs_rd;
    logic [35:0] cs_data = '0;
    logic        alu_n = 1'b0;
    logic        alu_z = 1'b0;
    logic [7:0]  mbr = '0;
    logic        mem_busy = 1'b0;
    logic [7:0]  alu_ctrl;
    logic [8:0]  c_ctrl;
    logic [3:0]  b_sel;
    logic        mem_write, mem_read, mem_fetch;
    logic        exec_valid;
    logic [8:0]  mpc;
    logic        halted;

    logic [35:0] cs_mem [512];

    int checks   = 0;
    int failures = 0;

    // Microinstruction-level model state
    logic [8:0]  mpc_m;
    logic [35:0] word_m, mir_m;
    bit          halted_m, expect_fetch, have_word;
    int          age;
    int          execs;

    mic1_microsequencer #(
        .CS_ADDR_W(9),
        .CS_DATA_W(36),
        .RESET_MPC(9'h000)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cs_addr    (cs_addr),
        .cs_rd      (cs_rd),
        .cs_data    (cs_data),
        .alu_n      (alu_n),
        .alu_z      (alu_z),
        .mbr        (mbr),
        .mem_busy   (mem_busy),
        .alu_ctrl   (alu_ctrl),
        .c_ctrl     (c_ctrl),
        .b_sel      (b_sel),
        .mem_write  (mem_write),
        .mem_read   (mem_read),
        .mem_fetch  (mem_fetch),
        .exec_valid (exec_valid),
        .mpc        (mpc),
        .halted     (halted)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cs_rd) cs_data <= cs_mem[cs_addr];
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [35:0] mkword(input logic [8:0] nxt, input logic [2:0] jam,
                                           input logic [7:0] alu, input logic [8:0] c,
                                           input logic [2:0] mem, input logic [3:0] b);
        return {nxt, jam, alu, c, mem, b};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) cs_mem[i] = '0;
    endtask

    task automatic model_reset();
        mpc_m        = 9'h000;
        mir_m        = '0;
        word_m       = '0;
        halted_m     = 1'b0;
        expect_fetch = 1'b1;
        have_word    = 1'b0;
        age          = 0;
    endtask

    task automatic monitor();
        logic [8:0] nxt;
        check("cs_addr", 64'(cs_addr), 64'(mpc_m));
        check("mpc", 64'(mpc), 64'(mpc_m));
        check("halted", 64'(halted), 64'(halted_m));
        check("alu_ctrl", 64'(alu_ctrl), 64'(mir_m[23:16]));
        check("c_ctrl", 64'(c_ctrl), 64'(mir_m[15:7]));
        check("b_sel", 64'(b_sel), 64'(mir_m[3:0]));
        if (expect_fetch) check("cs_rd", 64'(cs_rd), 64'(!mem_busy));
        else              check("cs_rd_idle", 64'(cs_rd), 64'(0));
        if (have_word && age >= 2) check("exec_valid", 64'(exec_valid), 64'(!mem_busy));
        else                       check("exec_idle", 64'(exec_valid), 64'(0));
        if (exec_valid) check("strobes", 64'({mem_write, mem_read, mem_fetch}), 64'(mir_m[6:4]));
        else            check("strobes_idle", 64'({mem_write, mem_read, mem_fetch}), 64'(0));

        if (cs_rd && expect_fetch) begin
            word_m       = cs_mem[mpc_m];
            have_word    = 1'b1;
            age          = 0;
            expect_fetch = 1'b0;
        end else if (exec_valid && have_word && age >= 2) begin
            nxt = word_m[35:27]
                | (word_m[26] ? {1'b0, mbr} : 9'h000)
                | (((word_m[25] && alu_n) || (word_m[24] && alu_z)) ? 9'h100 : 9'h000);
            if (word_m[26:24] == 3'b000 && word_m[35:27] == mpc_m) halted_m = 1'b1;
            else                                                 expect_fetch = 1'b1;
            mpc_m     = nxt;
            have_word = 1'b0;
            execs++;
        end
        if (have_word) begin
            if (age == 1) mir_m = word_m;
            age++;
        end
    endtask

    task automatic step(input bit rst, input bit busy, input bit n, input bit z, input logic [7:0] m);
        @(posedge clock);
        #1;
        reset    = rst;
        mem_busy = busy;
        alu_n    = n;
        alu_z    = z;
        mbr      = m;
        @(negedge clock);
        if (rst) begin
            model_reset();
            check("rst_cs_rd", 64'(cs_rd), 64'(0));
            check("rst_cs_addr", 64'(cs_addr), 64'(9'h000));
            check("rst_exec", 64'(exec_valid), 64'(0));
            check("rst_halted", 64'(halted), 64'(0));
            check("rst_strobes", 64'({mem_write, mem_read, mem_fetch}), 64'(0));
            check("rst_mir", 64'({alu_ctrl, c_ctrl, b_sel}), 64'(0));
        end else begin
            monitor();
        end
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 8'h00);
    endtask

    task automatic rstep();
        step(0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             8'($urandom_range(0, 255)));
    endtask

    // One branch word at 0x000; flags/mbr presented in its EXEC cycle.
    task automatic branch_case(input string tag, input logic [8:0] nxt, input logic [2:0] jam,
                               input bit n, input bit z, input logic [7:0] m, input logic [8:0] exp);
        clear_mem();
        cs_mem[0] = mkword(nxt, jam, 8'h00, 9'h000, 3'b000, 4'h0);
        do_reset();
        idle(2);
        step(0, 0, n, z, m);
        step(0, 0, 0, 0, 8'h00);
        check(tag, 64'(mpc), 64'(exp));
    endtask

    initial begin
        logic [63:0] r;
        int rd_cnt, ev_cnt, run;
        model_reset();
        execs = 0;

        // Basic fetch/load/exec timing and field decode
        clear_mem();
        cs_mem[0] = mkword(9'h005, 3'b000, 8'h3C, 9'h001, 3'b000, 4'h2);
        do_reset();
        step(0, 0, 0, 0, 8'h00);
        check("t1_cs_rd_c1", 64'(cs_rd), 64'(1));
        step(0, 0, 0, 0, 8'h00);
        check("t1_load_idle", 64'(exec_valid), 64'(0));
        step(0, 0, 0, 0, 8'h00);
        check("t1_exec_c3", 64'(exec_valid), 64'(1));
        check("t1_alu", 64'(alu_ctrl), 64'(8'h3C));
        check("t1_c", 64'(c_ctrl), 64'(9'h001));
        check("t1_b", 64'(b_sel), 64'(4'h2));
        step(0, 0, 0, 0, 8'h00);
        check("t1_mpc", 64'(mpc), 64'(9'h005));

        // JAM and JMPC branching
        branch_case("jamz_taken", 9'h010, 3'b001, 0, 1, 8'h00, 9'h110);
        branch_case("jamz_not",   9'h010, 3'b001, 1, 0, 8'h00, 9'h010);
        branch_case("jamn_taken", 9'h010, 3'b010, 1, 0, 8'h00, 9'h110);
        branch_case("jamn_not",   9'h010, 3'b010, 0, 1, 8'h00, 9'h010);
        branch_case("jmpc_59",    9'h100, 3'b100, 0, 0, 8'h59, 9'h159);
        branch_case("jmpc_ff",    9'h000, 3'b100, 1, 1, 8'hFF, 9'h0FF);

        // READ word with a two-cycle stall entering EXEC
        clear_mem();
        cs_mem[0] = mkword(9'h003, 3'b000, 8'h00, 9'h000, 3'b010, 4'h0);
        do_reset();
        idle(2);
        step(0, 1, 0, 0, 8'h00);
        check("stall1_exec", 64'({exec_valid, mem_read}), 64'(0));
        step(0, 1, 0, 0, 8'h00);
        check("stall2_exec", 64'({exec_valid, mem_read}), 64'(0));
        check("stall_mpc", 64'(mpc), 64'(9'h000));
        step(0, 0, 0, 0, 8'h00);
        check("stall_release", 64'({exec_valid, mem_read}), 64'(2'b11));
        step(0, 0, 0, 0, 8'h00);
        check("stall_after", 64'({exec_valid, mem_read}), 64'(0));
        check("stall_mpc_adv", 64'(mpc), 64'(9'h003));

        // mem_busy during LOAD does not delay EXEC
        do_reset();
        step(0, 0, 0, 0, 8'h00);
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        check("load_busy_exec", 64'(exec_valid), 64'(1));

        // Self-loop halt
        clear_mem();
        cs_mem[9'h000] = mkword(9'h020, 3'b000, 8'h00, 9'h000, 3'b000, 4'h0);
        cs_mem[9'h020] = mkword(9'h020, 3'b000, 8'h11, 9'h000, 3'b000, 4'h0);
        do_reset();
        ev_cnt = 0;
        rd_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 0, 8'h00);
            ev_cnt += int'(exec_valid);
        end
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'h00);
            ev_cnt += int'(exec_valid);
            rd_cnt += int'(cs_rd);
        end
        check("halt_flag", 64'(halted), 64'(1));
        check("halt_mpc", 64'(mpc), 64'(9'h020));
        check("halt_no_fetch", 64'(rd_cnt), 64'(0));
        check("halt_exec_cnt", 64'(ev_cnt), 64'(2));
        do_reset();
        step(0, 0, 0, 0, 8'h00);
        check("halt_cleared", 64'({halted, mpc}), 64'(0));

        // Async reset in the middle of a WRITE EXEC
        clear_mem();
        cs_mem[0] = mkword(9'h001, 3'b000, 8'hA5, 9'h1FF, 3'b100, 4'h7);
        do_reset();
        idle(3);
        check("wr_exec", 64'({exec_valid, mem_write}), 64'(2'b11));
        #2 reset = 1'b1;
        #1;
        check("wr_async_drop", 64'(mem_write), 64'(0));
        check("wr_async_exec", 64'(exec_valid), 64'(0));
        check("wr_async_mir", 64'({alu_ctrl, c_ctrl, b_sel}), 64'(0));
        model_reset();
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        check("wr_refetch", 64'({cs_rd, cs_addr}), 64'({1'b1, 9'h000}));

        // Random programs with random stalls, flags and occasional resets
        for (int seg = 0; seg < 3; seg++) begin
            for (int i = 0; i < 512; i++) begin
                r = {$urandom(), $urandom()};
                cs_mem[i] = r[35:0];
            end
            for (int k = 0; k < 8; k++) begin
                run = $urandom_range(0, 511);
                cs_mem[run] = mkword(9'(run), 3'b000, 8'h00, 9'h000, 3'b000, 4'h0);
            end
            run = execs;
            do_reset();
            for (int i = 0; i < 300; i++) begin
                if ((halted_m && $urandom_range(0, 3) == 0) || $urandom_range(0, 149) == 0)
                    step(1, 0, 0, 0, 8'h00);
                else
                    rstep();
            end
            check("rand_progress", 64'(execs - run > 20), 64'(1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
